// File: rtl/pdb_seq_pkg.sv
// Shared definitions for the PDB power sequencers: FSM state codes,
// common millisecond delay constants and an elaboration-time clog2.
package pdb_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_PG = 2'd1,
        STAGGER = 2'd2
    } state_e;

    // Delays expressed in 1 ms ticks
    localparam int unsigned dly_1ms   = 1;
    localparam int unsigned dly_5ms   = 5;
    localparam int unsigned dly_10ms  = 10;
    localparam int unsigned dly_20ms  = 20;
    localparam int unsigned dly_100ms = 100;
    localparam int unsigned dly_1s    = 1000;
    localparam int unsigned dly_5s    = 5000;

    // Bits needed to index 'value' distinct codes; never less than 1
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        if (res < 1) res = 1;
        return res;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first pending slot after i_last, with wrap.
module rr_pick
    import pdb_seq_pkg::*;
#(
    parameter int NODES = 4
) (
    input  logic [NODES-1:0] i_pending,
    input  logic [2:0]       i_last,
    output logic             o_valid,
    output logic [2:0]       o_idx
);

    localparam int IW = clog2(NODES);

    logic [NODES-1:0] w_hit;
    logic [2:0]       w_cand [NODES];

    // Candidate gi is the slot gi+1 positions after the last grant
    for (genvar gi = 0; gi < NODES; gi++) begin : g_cand
        localparam int OFF = gi + 1;
        assign w_cand[gi] = 3'((int'(i_last) + OFF) % NODES);
        assign w_hit[gi]  = i_pending[w_cand[gi][IW-1:0]];
    end

    // Scan from the farthest candidate down so the nearest hit wins
    always_comb begin
        o_valid = 1'b0;
        o_idx   = i_last;
        for (int k = NODES - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                o_valid = 1'b1;
                o_idx   = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/node_pwr_stagger_arb.sv
// Staggered per-node P12V power-on arbiter: one grant at a time, round-robin,
// with a power-good window, bounded retries and an inter-grant gap.
module node_pwr_stagger_arb
    import pdb_seq_pkg::*;
#(
    parameter int NODES         = 4,
    parameter int STAGGER_MS    = dly_20ms,
    parameter int PG_TIMEOUT_MS = 150,
    parameter int RETRY_MAX     = 2
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iTick_1ms,
    input  logic             iEnable,
    input  logic [NODES-1:0] iReq,
    input  logic [NODES-1:0] iPwrgd,
    input  logic             iFault_Clear,
    output logic [NODES-1:0] oNode_EN,
    output logic [NODES-1:0] oNode_Fault,
    output logic             oBusy,
    output logic [2:0]       oGrant_Idx,
    output logic [3:0]       oDBG_State
);

    localparam int CNT_MAX = (STAGGER_MS > PG_TIMEOUT_MS) ? STAGGER_MS : PG_TIMEOUT_MS;
    localparam int CW      = clog2(CNT_MAX + 1);
    localparam int RW      = clog2(RETRY_MAX + 2);
    localparam int IW      = clog2(NODES);

    localparam logic [CW-1:0] PG_TO   = CW'(PG_TIMEOUT_MS);
    localparam logic [CW-1:0] ST_GAP  = CW'(STAGGER_MS);
    localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);
    localparam logic [RW-1:0] RT_LAST = RW'(RETRY_MAX);
    localparam logic [RW-1:0] RT_TOP  = RW'(RETRY_MAX + 1);

    state_e           r_state;
    logic [CW-1:0]    r_cnt;
    logic [NODES-1:0] r_en;
    logic [NODES-1:0] r_fault;
    logic [NODES-1:0] r_pg_seen;
    logic [RW-1:0]    r_retry [NODES];
    logic [2:0]       r_grant;

    logic [NODES-1:0] w_pending;
    logic             w_valid;
    logic [2:0]       w_idx;
    logic [IW-1:0]    w_gi;
    logic [CW-1:0]    w_cnt_inc;

    assign w_pending = iReq & ~r_en & ~r_fault;
    assign w_gi      = r_grant[IW-1:0];
    assign w_cnt_inc = (iTick_1ms && (r_cnt != CNT_TOP)) ? r_cnt + CW'(1) : r_cnt;

    rr_pick #(.NODES(NODES)) u_rr_pick (
        .i_pending (w_pending),
        .i_last    (r_grant),
        .o_valid   (w_valid),
        .o_idx     (w_idx)
    );

    // Later assignments in this block override earlier ones, which encodes the
    // priorities: request drop > FSM outcome > runtime loss > fault clear.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_en      <= '0;
            r_fault   <= '0;
            r_pg_seen <= '0;
            r_grant   <= '0;
            for (int k = 0; k < NODES; k++) r_retry[k] <= '0;
        end else if (!iEnable) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_en      <= '0;
            r_pg_seen <= '0;
        end else begin
            if (iFault_Clear) begin
                r_fault <= '0;
                for (int k = 0; k < NODES; k++) r_retry[k] <= '0;
            end

            for (int k = 0; k < NODES; k++) begin
                if (r_en[k] && r_pg_seen[k] && !iPwrgd[k]) begin
                    r_en[k]      <= 1'b0;
                    r_pg_seen[k] <= 1'b0;
                    r_fault[k]   <= 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_valid) begin
                        r_en[w_idx[IW-1:0]] <= 1'b1;
                        r_grant             <= w_idx;
                        r_state             <= WAIT_PG;
                    end
                end
                WAIT_PG: begin
                    if (iPwrgd[w_gi]) begin
                        r_pg_seen[w_gi] <= 1'b1;
                        r_retry[w_gi]   <= '0;
                        r_state         <= STAGGER;
                        r_cnt           <= '0;
                    end else if (r_cnt == PG_TO) begin
                        r_en[w_gi] <= 1'b0;
                        if (r_retry[w_gi] != RT_TOP) r_retry[w_gi] <= r_retry[w_gi] + RW'(1);
                        if (r_retry[w_gi] == RT_LAST) r_fault[w_gi] <= 1'b1;
                        r_state <= STAGGER;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                STAGGER: begin
                    if (r_cnt == ST_GAP) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase

            for (int k = 0; k < NODES; k++) begin
                if (r_en[k] && !iReq[k]) begin
                    r_en[k]      <= 1'b0;
                    r_pg_seen[k] <= 1'b0;
                    r_retry[k]   <= '0;
                    if ((r_state == WAIT_PG) && (int'(w_gi) == k)) begin
                        r_state <= STAGGER;
                        r_cnt   <= '0;
                    end
                end
            end
        end
    end

    assign oNode_EN    = r_en;
    assign oNode_Fault = r_fault;
    assign oGrant_Idx  = r_grant;
    assign oBusy       = (r_state != IDLE);
    assign oDBG_State  = {2'b00, r_state};

endmodule

// File: doc/node_pwr_stagger_arb.md
Name: node_pwr_stagger_arb

Overview:
Staggered power-on arbiter for the per-node P12V enables on the PDB. It grants node power-on one node at a time in round-robin order, which limits inrush on the shared P12V rail. Each grant is followed by a power-good watch window, bounded retries and a stagger gap before the next grant. It sits downstream of the master sequencer: the master's "all rails up" state drives iEnable, and this block owns the individual node enables.

Parameters:
NODES, 4, number of node power slots (2..8)
STAGGER_MS, 20, gap in 1 ms ticks between end of one grant and next grant
PG_TIMEOUT_MS, 150, ticks allowed for iPwrgd after enable
RETRY_MAX, 2, timeouts tolerated per node before the fault latches (fault on timeout RETRY_MAX+1)

Ports:
iClk  in  1  module clock (2 MHz)
iRst  in  1  synchronous reset, active-high
iTick_1ms  in  1  single-cycle strobe, once per ms, synchronous to iClk
iEnable  in  1  master sequencer permits node power; low = shed all
iReq  in  NODES  per-node power request, level
iPwrgd  in  NODES  per-node P12V power-good
iFault_Clear  in  1  single-cycle pulse, clears all latched faults and retry counts
oNode_EN  out  NODES  per-node P12V enable, registered
oNode_Fault  out  NODES  sticky per-node fault
oBusy  out  1  FSM not in IDLE
oGrant_Idx  out  3  index of node currently granted or last granted
oDBG_State  out  4  current FSM state code

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: oNode_EN=0, oNode_Fault=0, oBusy=0, oGrant_Idx=0, oDBG_State=IDLE. Tick counter=0, RR pointer=0, all retry counters=0, all pg_seen=0.
- Pending[i] = iReq[i] & ~oNode_EN[i] & ~oNode_Fault[i].
- States: IDLE(0), WAIT_PG(1), STAGGER(2).
- IDLE, iEnable=1 and any Pending:
  - Pick first pending index searching from (last_grant+1) mod NODES upward, with wrap.
  - Set oNode_EN[idx]=1 and oGrant_Idx=idx.
  - Clear the counter and go to WAIT_PG. The enable is visible 1 cycle after the decision.
- WAIT_PG:
  - Counter increments on each iTick_1ms.
  - iPwrgd[idx]=1: set pg_seen[idx], clear retry[idx], go to STAGGER with counter cleared.
  - Else counter == PG_TIMEOUT_MS: oNode_EN[idx]=0 and retry[idx]++. If retry[idx] was already RETRY_MAX, set oNode_Fault[idx]. Go to STAGGER with counter cleared.
  - Pwrgd has priority over timeout in the same cycle.
- STAGGER: counter increments on tick; at counter == STAGGER_MS go to IDLE. The next grant is therefore at least STAGGER_MS ticks after the previous outcome.
- iReq[i] falls while oNode_EN[i]=1, in any state:
  - Next cycle oNode_EN[i]=0, pg_seen[i]=0, retry[i]=0.
  - If i is the node in WAIT_PG, go to STAGGER (counter cleared).
- Runtime loss: oNode_EN[i]=1 & pg_seen[i]=1 & iPwrgd[i]=0 gives, next cycle, oNode_EN[i]=0 and oNode_Fault[i]=1. There are no retries for runtime loss.
- iEnable=0, highest priority except reset: next cycle all oNode_EN=0, pg_seen=0, counter=0, FSM to IDLE. Faults and retry counts are kept.
- iFault_Clear: clears oNode_Fault and retry counts next cycle. If it coincides with a fault-set event, the set wins.
- Simultaneous requests are resolved only by the RR pointer; never grant two nodes in one cycle.
- Counter width is clog2(max(STAGGER_MS, PG_TIMEOUT_MS)+1); it saturates, never wraps.
- oBusy = (state != IDLE). oDBG_State is the state code zero-extended to 4 bits.
- A mid-operation iRst returns every output to its reset value on the next edge.

Decomposition:
- Package pdb_seq_pkg holds:
  - State localparams IDLE/WAIT_PG/STAGGER.
  - Shared delay constants (dly_1ms..dly_5s) reused by sequencers.
  - A clog2 function.
- Sub-module rr_pick (NODES parameter): combinational round-robin first-one finder. Inputs are the pending vector and the last index; outputs are a valid bit and the index.

Test Plan:
1. Reset, iEnable=1, iReq=4'b1111, each iPwrgd rises 5 ticks after its EN -> EN order node1,2,3,0 (pointer starts at 0, search from 1). Consecutive EN rises are 25 ticks apart. oNode_Fault=0.
2. iReq=4'b0001, iPwrgd[0] held 0 -> EN[0] high 150 ticks, low 20, re-granted. After the third timeout oNode_Fault[0]=1, EN[0]=0, no further grant. iFault_Clear -> fault 0, node re-granted after the stagger.
3. Node2 powered with pg_seen=1, then iPwrgd[2] drops -> next cycle EN[2]=0, oNode_Fault[2]=1. Other nodes unaffected.
4. iReq=4'b0110 granted; mid-WAIT_PG of node2 drop iEnable -> next cycle oNode_EN=0000, FSM=IDLE. Restore iEnable -> re-grant starting at node after last grant.
5. iPwrgd[idx] rises on the exact cycle the counter hits 150 -> success path: EN stays 1, retry not incremented.
6. iReq[1] drops during node1 WAIT_PG -> EN[1]=0 next cycle, FSM to STAGGER, next grant 20 ticks later.
